branch_predictor_table: RTL and testbench

Parametrised branch direction predictor: a table of 2^INDEX_W saturating counters, indexed by branch PC, optionally hashed with a global taken/not-taken history (gshare). It answers one prediction request per cycle and accepts one resolved-branch update per cycle. It also counts mispredictions. It supersedes the single-counter predictor in the fetch path, adding per-branch state, a configurable counter width, history hashing and reset.

---
 rtl/branch_predictor_table.sv | 161 ++++++++++++++++
 tb/tb_branch_predictor_table.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_table.sv
// Branch direction predictor: a table of saturating counters indexed by the
// branch PC, optionally hashed with a non-speculative global history (gshare).
// It serves one registered prediction and one resolved-branch update per
// cycle, and keeps a saturating mispredict count.

// One table entry: a CTR_W-bit saturating up/down counter.
module bpt_ctr #(
    parameter int CTR_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic upd_en,
    input  logic upd_taken,
    output logic ctr_msb
);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [CTR_W-1:0] ctr;

    // Count toward taken/not-taken; pin at the ends instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr <= '0;
        end else if (upd_en) begin
            if (upd_taken) begin
                if (ctr != CTR_MAX) ctr <= ctr + CTR_W'(1);
            end else begin
                if (ctr != '0) ctr <= ctr - CTR_W'(1);
            end
        end
    end

    assign ctr_msb = ctr[CTR_W-1];
endmodule

module branch_predictor_table #(
    parameter int PC_W    = 8,
    parameter int INDEX_W = 4,
    parameter int CTR_W   = 2,
    parameter int HIST_W  = 4,
    parameter int MODE    = 1,
    parameter int MISS_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [PC_W-1:0]   req_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic [MISS_W-1:0] miss_count
);
    localparam int DEPTH = 1 << INDEX_W;
    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    // Resolved-branch update as seen by the table this cycle.
    typedef struct packed {
        logic               valid;
        logic [INDEX_W-1:0] idx;
        logic               taken;
        logic               miss;
    } upd_req_t;

    logic [HIST_W-1:0]  ghist;
    logic [HIST_W-1:0]  ghist_nxt;
    logic [INDEX_W-1:0] hist_ext;
    logic [INDEX_W-1:0] hash;
    logic [INDEX_W-1:0] req_idx;
    upd_req_t           upd;
    logic [DEPTH-1:0]   upd_hit;
    logic [DEPTH-1:0]   ctr_msb;
    logic [1:0]         vld_pipe;

    // History zero-extended on the MSB side to the index width.
    always_comb begin
        hist_ext = '0;
        hist_ext[HIST_W-1:0] = ghist;
    end

    generate
        if (MODE == 1) begin : g_gshare
            assign hash = hist_ext;
        end else begin : g_bimodal
            assign hash = '0;
        end
    endgenerate

    // Request and update both hash with the pre-shift history, so a same-cycle
    // request sees the table exactly as it was before this edge.
    assign req_idx   = req_pc[INDEX_W-1:0] ^ hash;
    assign upd.valid = upd_valid;
    assign upd.idx   = upd_pc[INDEX_W-1:0] ^ hash;
    assign upd.taken = upd_taken;
    assign upd.miss  = upd_pred ^ upd_taken;

    // Upper PC bits do not take part in the index.
    generate
        if (PC_W > INDEX_W) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^{req_pc[PC_W-1:INDEX_W], upd_pc[PC_W-1:INDEX_W]};
        end
    endgenerate

    // One-hot write enable for the addressed entry.
    always_comb begin
        upd_hit = '0;
        if (upd.valid) upd_hit[upd.idx] = 1'b1;
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            bpt_ctr #(.CTR_W(CTR_W)) u_ctr (
                .clk       (clk),
                .reset     (reset),
                .upd_en    (upd_hit[i]),
                .upd_taken (upd.taken),
                .ctr_msb   (ctr_msb[i])
            );
        end
    endgenerate

    // Newest outcome enters at the LSB; a 1-bit history just loads it.
    generate
        if (HIST_W == 1) begin : g_hist1
            assign ghist_nxt = upd.taken;
        end else begin : g_histn
            assign ghist_nxt = {ghist[HIST_W-2:0], upd.taken};
        end
    endgenerate

    // History advances only on resolved updates.
    always_ff @(posedge clk) begin
        if (reset) ghist <= '0;
        else if (upd.valid) ghist <= ghist_nxt;
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (reset) miss_count <= '0;
        else if (upd.valid && upd.miss && miss_count != MISS_MAX)
            miss_count <= miss_count + MISS_W'(1);
    end

    assign vld_pipe[0] = req_valid;

    // Registered prediction; direction holds when no request is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe[1] <= 1'b0;
            pred_taken  <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (req_valid) pred_taken <= ctr_msb[req_idx];
        end
    end

    assign pred_valid = vld_pipe[1];
endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: three instances (gshare default, bimodal,
// 2-bit miss counter) share one stimulus stream and are compared every cycle
// against an arithmetic model, plus directed checks with literal expectations.
module tb_branch_predictor_table;
    logic       clk = 1'b0;
    logic       reset, req_valid, upd_valid, upd_taken, upd_pred;
    logic [7:0] req_pc, upd_pc;

    logic        pv [3];
    logic        pt [3];
    logic [15:0] miss0, miss1;
    logic [1:0]  miss2;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance.
    int ctr   [3][16];
    int ghist [3];
    int miss  [3];
    int epv   [3];
    int ept   [3];
    int mode_k    [3] = '{1, 0, 1};
    int miss_max  [3] = '{65535, 65535, 3};

    always #5 clk = ~clk;

    branch_predictor_table #(.MODE(1)) u_gs (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(pv[0]), .pred_taken(pt[0]), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .miss_count(miss0));

    branch_predictor_table #(.MODE(0)) u_bim (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(pv[1]), .pred_taken(pt[1]), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .miss_count(miss1));

    branch_predictor_table #(.MODE(1), .MISS_W(2)) u_sat (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(pv[2]), .pred_taken(pt[2]), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .miss_count(miss2));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int idx_of(int k, int pc, int gh);
        return mode_k[k] == 1 ? ((pc % 16) ^ gh) : (pc % 16);
    endfunction

    // What one clock edge does to instance k, from the behavioural rules.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                for (int e = 0; e < 16; e++) ctr[k][e] = 0;
                ghist[k] = 0; miss[k] = 0; epv[k] = 0; ept[k] = 0;
            end else begin
                int gh = ghist[k];
                epv[k] = req_valid;
                if (req_valid) ept[k] = (ctr[k][idx_of(k, req_pc, gh)] >= 2) ? 1 : 0;
                if (upd_valid) begin
                    int ui = idx_of(k, upd_pc, gh);
                    if (upd_taken) ctr[k][ui] = (ctr[k][ui] < 3) ? ctr[k][ui] + 1 : 3;
                    else           ctr[k][ui] = (ctr[k][ui] > 0) ? ctr[k][ui] - 1 : 0;
                    ghist[k] = (gh * 2 + int'(upd_taken)) % 16;
                    if (upd_pred != upd_taken && miss[k] < miss_max[k]) miss[k]++;
                end
            end
        end
    endtask

    task automatic cycle(input bit rs, input bit rv, input int rpc,
                         input bit uv, input int upc, input bit ut, input bit up);
        reset = rs; req_valid = rv; req_pc = 8'(rpc);
        upd_valid = uv; upd_pc = 8'(upc); upd_taken = ut; upd_pred = up;
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("pv%0d", k), int'(pv[k]), epv[k]);
            chk($sformatf("pt%0d", k), int'(pt[k]), ept[k]);
        end
        chk("miss0", int'(miss0), miss[0]);
        chk("miss1", int'(miss1), miss[1]);
        chk("miss2", int'(miss2), miss[2]);
    endtask

    task automatic do_reset();   cycle(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic req(input int pc); cycle(0, 1, pc, 0, 0, 0, 0); endtask
    task automatic upd(input int pc, input bit t, input bit p); cycle(0, 0, 0, 1, pc, t, p); endtask

    initial begin
        reset = 1; req_valid = 0; upd_valid = 0; upd_taken = 0; upd_pred = 0;
        req_pc = '0; upd_pc = '0;
        @(negedge clk);
        do_reset(); do_reset();
        chk("rst_pv", int'(pv[0]), 0);
        chk("rst_pt", int'(pt[0]), 0);

        // Reset state, first request.
        req(8'h05);
        chk("first_pv", int'(pv[0]), 1);
        chk("first_pt", int'(pt[0]), 0);
        chk("first_miss", int'(miss0), 0);

        // Bimodal training and saturation on pc 3.
        upd(3, 1, 1); upd(3, 1, 1); req(3);
        chk("bim_ctr2", int'(pt[1]), 1);
        upd(3, 1, 1); upd(3, 1, 1); req(3);
        chk("bim_sat", int'(pt[1]), 1);
        upd(3, 0, 1); req(3);
        chk("bim_ctr2b", int'(pt[1]), 1);
        upd(3, 0, 1); req(3);
        chk("bim_ctr1", int'(pt[1]), 0);

        // Gshare indexing from reset.
        do_reset();
        upd(0, 1, 1); req(1);
        chk("gs_idx0", int'(pt[0]), 0);
        upd(0, 1, 1); req(3);
        chk("gs_idx0b", int'(pt[0]), 0);

        // Same-cycle hazard on entry 0 (counter 1, ghist 0011).
        cycle(0, 1, 3, 1, 3, 1, 1);
        chk("haz_old", int'(pt[0]), 0);
        req(7);
        chk("haz_new", int'(pt[0]), 1);

        // Mispredict accounting.
        do_reset();
        for (int i = 0; i < 5; i++) upd(i, 1, 0);
        for (int i = 0; i < 3; i++) upd(i, 0, 0);
        chk("miss5", int'(miss0), 5);
        chk("miss_sat3", int'(miss2), 3);
        upd(9, 0, 1);
        chk("miss_held", int'(miss2), 3);
        chk("miss6", int'(miss0), 6);

        // Reset mid-stream discards the request and update in that cycle.
        upd(2, 1, 1); upd(2, 1, 1); upd(2, 1, 1);
        cycle(1, 1, 2, 1, 2, 1, 0);
        chk("mid_pv", int'(pv[1]), 0);
        req(2);
        chk("mid_pt", int'(pt[1]), 0);
        chk("mid_miss", int'(miss1), 0);

        // Random traffic, occasional reset, narrow PC set to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 255), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
